bbs_bit_packer: RTL

- Downstream consumer of the BBS generator's per-clock LSB output stream.
- Optionally whitens the stream with a von Neumann extractor.
- Packs accepted bits LSB-first into WORD_W-bit words and buffers them in a small FIFO.
- Presents words to the system over a valid/ready handshake; flags and counts words lost to back-pressure.

---
 rtl/bbs_pkg.sv | 14 +
 rtl/bbs_word_fifo.sv | 51 +++++
 rtl/bbs_bit_packer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/bbs_pkg.sv
// Shared constants and types for the BBS bit packer.
package bbs_pkg;

   localparam int WORD_W_DEF     = 8;
   localparam int FIFO_DEPTH_DEF = 4;
   localparam int DROP_CNT_W     = 16;

   // Von Neumann extractor pair state
   typedef enum logic {
      DB_EMPTY      = 1'b0,
      DB_HAVE_FIRST = 1'b1
   } db_state_t;

endpackage

// File: rtl/bbs_word_fifo.sv
// Synchronous word FIFO with occupancy output. A push into a full FIFO is
// accepted only if a pop happens on the same edge; otherwise it is ignored.
module bbs_word_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [W-1:0]     wdata,
   input  logic             pop,
   output logic [W-1:0]     rdata,
   output logic [LVL_W-1:0] level,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign full  = (level == LVL_W'(DEPTH));
   assign empty = (level == '0);
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;
   assign rdata = mem[rd_ptr];

   // Storage, pointers (wrap naturally, DEPTH is a power of two) and level
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
         if (wr_en && !rd_en)      level <= level + LVL_W'(1);
         else if (!wr_en && rd_en) level <= level - LVL_W'(1);
      end
   end

endmodule

// File: rtl/bbs_bit_packer.sv
// Packs the BBS generator bit stream (optionally von Neumann whitened)
// LSB-first into words, buffers them and reports back-pressure drops.
//
// Debias FSM:
//   state          | meaning
//   DB_EMPTY       | no pending bit of the current pair
//   DB_HAVE_FIRST  | first bit of a pair stored, waiting for the second
module bbs_bit_packer
   import bbs_pkg::*;
#(
   parameter int WORD_W     = WORD_W_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int DEBIAS     = 1
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          bit_in,
   input  logic                          bit_valid,
   input  logic                          enable,
   output logic [WORD_W-1:0]             word_out,
   output logic                          word_valid,
   input  logic                          word_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   output logic [DROP_CNT_W-1:0]         drop_count,
   input  logic                          clear_ovf
);

   localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   logic              accepted;
   logic              emit;
   logic              emit_bit;
   logic [WORD_W-1:0] acc;
   logic [WORD_W-1:0] word_next;
   logic [CNT_W-1:0]  bit_cnt;
   logic              last_bit;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic              drop;

   assign accepted = bit_valid & enable;

   generate
      if (DEBIAS != 0) begin : g_debias
         db_state_t db_state;
         logic      first_bit;

         assign emit     = accepted && (db_state == DB_HAVE_FIRST) && (first_bit != bit_in);
         assign emit_bit = first_bit;

         // Pair tracking: store the first bit, resolve on the second
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               db_state  <= DB_EMPTY;
               first_bit <= 1'b0;
            end else if (accepted) begin
               if (db_state == DB_EMPTY) begin
                  first_bit <= bit_in;
                  db_state  <= DB_HAVE_FIRST;
               end else begin
                  db_state  <= DB_EMPTY;
               end
            end
         end
      end else begin : g_raw
         assign emit     = accepted;
         assign emit_bit = bit_in;
      end
   endgenerate

   assign last_bit = (bit_cnt == CNT_W'(WORD_W - 1));
   assign push     = emit && last_bit;
   assign pop      = word_valid && word_ready;
   assign drop     = push && full && !pop;

   // Accumulator with the emitted bit merged in, so a completing bit is pushed the same edge
   always_comb begin
      word_next          = acc;
      word_next[bit_cnt] = emit_bit;
   end

   // Accumulator and bit position; stale upper bits are overwritten before reuse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc     <= '0;
         bit_cnt <= '0;
      end else if (emit) begin
         acc     <= word_next;
         bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
      end
   end

   // Sticky overflow and saturating drop counter; a clear wins, then a same-edge drop counts
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (clear_ovf) begin
         overflow   <= drop;
         drop_count <= drop ? DROP_CNT_W'(1) : '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_count != '1) drop_count <= drop_count + DROP_CNT_W'(1);
      end
   end

   bbs_word_fifo #(
      .W     (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .wdata   (word_next),
      .pop     (pop),
      .rdata   (word_out),
      .level   (fifo_level),
      .full    (full),
      .empty   (empty)
   );

   assign word_valid = !empty;

endmodule
